// File: rtl/exec_datapath.sv
// exec_datapath: multicycle execute stage with an internal register file.
// One decoded op is accepted at a time over op_valid/op_ready. It executes as
// a one-cycle ALU op, a bit-serial shift or a shift-add multiply. It then
// commits to the register file, result and psr in a single edge.
//
// Handshake: an op is accepted on a rising edge where op_valid && op_ready.
// op_ready depends only on the FSM state (high in IDLE). All op inputs are
// sampled on that edge only. A source that sees op_ready low must hold its
// op until it is accepted.
module exec_datapath #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [3:0]         opcode,
    input  logic [REGBITS-1:0] rdest,
    input  logic [REGBITS-1:0] rsrc,
    input  logic [WIDTH-1:0]   imm,
    input  logic               use_imm,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic [4:0]         psr,
    input  logic [REGBITS-1:0] dbg_raddr,
    output logic [WIDTH-1:0]   dbg_rdata,
    output logic [1:0]         dbg_state
);

    localparam int NREG = 1 << REGBITS;
    localparam int CW   = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_MUL   = 2'd3;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_CMP = 4'd6;
    localparam logic [3:0] OP_LSH = 4'd7;
    localparam logic [3:0] OP_ASH = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    // psr bit positions: {N, Z, F, L, C}
    localparam int P_N = 4;
    localparam int P_Z = 3;
    localparam int P_F = 2;
    localparam int P_L = 1;
    localparam int P_C = 0;

    logic [WIDTH-1:0]   r_regs [NREG];
    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [3:0]         r_op;
    logic [REGBITS-1:0] r_rd;
    logic [CW-1:0]      r_cnt;
    logic               r_left;
    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic [4:0]         r_psr;

    logic               w_accept;
    logic [WIDTH-1:0]   w_b_in;
    logic [7:0]         w_amt8;
    logic               w_neg;
    logic [7:0]         w_mag;
    logic [CW-1:0]      w_n;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [WIDTH-1:0]   w_alu_val;
    logic               w_alu_wr;
    logic [4:0]         w_alu_psr;
    logic               w_fill;
    logic [WIDTH-1:0]   w_shift_step;
    logic               w_commit;
    logic               w_wr;
    logic [WIDTH-1:0]   w_val;
    logic [4:0]         w_psr_n;

    assign op_ready  = (r_state == S_IDLE);
    assign w_accept  = op_valid && (r_state == S_IDLE);
    assign w_b_in    = use_imm ? imm : r_regs[rsrc];
    assign done      = r_done;
    assign result    = r_result;
    assign psr       = r_psr;
    assign dbg_rdata = r_regs[dbg_raddr];
    assign dbg_state = r_state;

    // Shift amount: signed B[7:0]; magnitude saturated to WIDTH, sign picks direction
    assign w_amt8 = w_b_in[7:0];
    assign w_neg  = w_amt8[7];
    assign w_mag  = w_neg ? (8'd0 - w_amt8) : w_amt8;
    assign w_n    = (int'(w_mag) > WIDTH) ? CW'(WIDTH) : CW'(w_mag);

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};
    assign w_dif = {1'b0, r_a} - {1'b0, r_b};

    // One-bit shift step; ASH right shifts replicate the sign bit
    assign w_fill       = (r_op == OP_ASH) ? r_a[WIDTH-1] : 1'b0;
    assign w_shift_step = r_left ? {r_a[WIDTH-2:0], 1'b0} : {w_fill, r_a[WIDTH-1:1]};

    // Single-cycle ALU: value, write enable and next flags for EXEC ops
    always_comb begin
        w_alu_val = r_b;
        w_alu_wr  = 1'b0;
        w_alu_psr = r_psr;
        case (r_op)
            OP_ADD: begin
                w_alu_val        = w_sum[WIDTH-1:0];
                w_alu_wr         = 1'b1;
                w_alu_psr[P_C]   = w_sum[WIDTH];
                w_alu_psr[P_F]   = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                   (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_val        = w_dif[WIDTH-1:0];
                w_alu_wr         = 1'b1;
                w_alu_psr[P_C]   = w_dif[WIDTH];
                w_alu_psr[P_F]   = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                   (w_dif[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_AND: begin
                w_alu_val = r_a & r_b;
                w_alu_wr  = 1'b1;
            end
            OP_OR: begin
                w_alu_val = r_a | r_b;
                w_alu_wr  = 1'b1;
            end
            OP_XOR: begin
                w_alu_val = r_a ^ r_b;
                w_alu_wr  = 1'b1;
            end
            OP_MOV: begin
                w_alu_val = r_b;
                w_alu_wr  = 1'b1;
            end
            OP_CMP: begin
                w_alu_psr[P_Z] = (r_a == r_b);
                w_alu_psr[P_L] = (r_a < r_b);
                w_alu_psr[P_N] = ($signed(r_a) < $signed(r_b));
            end
            default: begin
                w_alu_wr = 1'b0;
            end
        endcase
    end

    // Commit decision and the value/flags that land on the commit edge
    always_comb begin
        w_commit = 1'b0;
        w_wr     = 1'b0;
        w_val    = w_alu_val;
        w_psr_n  = r_psr;
        case (r_state)
            S_EXEC: begin
                w_commit = 1'b1;
                w_wr     = w_alu_wr;
                w_val    = w_alu_val;
                w_psr_n  = w_alu_psr;
            end
            S_SHIFT: begin
                if (r_cnt == '0) begin
                    w_commit = 1'b1;
                    w_wr     = 1'b1;
                    w_val    = r_a;
                end
            end
            S_MUL: begin
                if (r_cnt == '0) begin
                    w_commit = 1'b1;
                    w_wr     = 1'b1;
                    w_val    = r_acc;
                end
            end
            default: begin
                w_commit = 1'b0;
            end
        endcase
    end

    // FSM and operand/iteration registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_op    <= '0;
            r_rd    <= '0;
            r_cnt   <= '0;
            r_left  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a   <= r_regs[rdest];
                        r_b   <= w_b_in;
                        r_op  <= opcode;
                        r_rd  <= rdest;
                        r_acc <= '0;
                        if (opcode == OP_LSH || opcode == OP_ASH) begin
                            r_cnt   <= w_n;
                            r_left  <= ~w_neg;
                            r_state <= S_SHIFT;
                        end else if (opcode == OP_MUL) begin
                            r_cnt   <= CW'(WIDTH);
                            r_state <= S_MUL;
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    r_state <= S_IDLE;
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_a   <= w_shift_step;
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    // S_MUL: one multiplier bit per cycle, LSB first
                    if (r_cnt != '0) begin
                        if (r_b[0]) begin
                            r_acc <= r_acc + r_a;
                        end
                        r_a   <= {r_a[WIDTH-2:0], 1'b0};
                        r_b   <= {1'b0, r_b[WIDTH-1:1]};
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Register file write port, used only on the commit edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && w_wr) begin
            r_regs[r_rd] <= w_val;
        end
    end

    // Architectural outputs: done pulse, last written value, status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done   <= 1'b0;
            r_result <= '0;
            r_psr    <= '0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                if (w_wr) begin
                    r_result <= w_val;
                end
                r_psr <= w_psr_n;
            end
        end
    end

endmodule
